// File: rtl/add32_unit.sv
// Registered 64-bit adder with unsigned carry-out.
// The sum comes from an explicit ripple chain of full-adder cells and is registered once.

module add32_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_ci,
   output logic o_s,
   output logic o_co
);
   logic w_p;

   assign w_p  = i_a ^ i_b;
   assign o_s  = w_p ^ i_ci;
   assign o_co = (i_a & i_b) | (i_ci & w_p);
endmodule

module add32_unit #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic             carry
);
   logic [WIDTH:0]   w_cy;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] r_c;
   logic             r_carry;

   // Bit 0 has no carry-in; w_cy[WIDTH] is the unsigned carry-out.
   assign w_cy[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      add32_fa u_fa (
         .i_a  (a[i]),
         .i_b  (b[i]),
         .i_ci (w_cy[i]),
         .o_s  (w_sum[i]),
         .o_co (w_cy[i+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_c     <= '0;
         r_carry <= 1'b0;
      end else begin
         r_c     <= w_sum;
         r_carry <= w_cy[WIDTH];
      end
   end

   assign c     = r_c;
   assign carry = r_carry;
endmodule

// File: tb/tb_add32_unit.sv
// Scoreboard bench for add32_unit: each driven edge pushes its expected {carry,c},
// which is popped and compared once the registered result is visible.

module tb_add32_unit;
   logic        clk;
   logic        rst;
   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] c;
   logic        carry;

   logic [64:0] exp_q[$];
   int          n_cmp;
   int          n_err;

   add32_unit #(.WIDTH(64)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .c     (c),
      .carry (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one edge's worth of inputs, record the expected result, and
   // return 1 ns after the edge that registers it.
   task automatic drive(input logic [63:0] da, input logic [63:0] db, input logic dr);
      a   = da;
      b   = db;
      rst = dr;
      if (dr) exp_q.push_back(65'd0);
      else    exp_q.push_back({1'b0, da} + {1'b0, db});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [64:0] e;
      for (int i = 0; i < 3; i++) begin
         drive(64'd5, 64'd7, (i < 2));
         e = exp_q.pop_front();
         n_cmp++;
         if ({carry, c} !== e) begin
            n_err++;
            $display("FAIL reset[%0d]: got carry=%b c=%h, want carry=%b c=%h", i, carry, c, e[64], e[63:0]);
         end
      end
      // Independent literal check of the first post-reset result.
      n_cmp++;
      if (c !== 64'd12 || carry !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: got carry=%b c=%h, want carry=0 c=c", carry, c);
      end
   endtask

   task automatic test_boundaries();
      logic [63:0] ta[6];
      logic [63:0] tb_v[6];
      logic [64:0] lit[6];
      logic [64:0] e;
      ta[0] = 64'h1;                   tb_v[0] = 64'hFFFF_FFFF_FFFF_FFFF; lit[0] = {1'b1, 64'h0};
      ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb_v[1] = 64'hFFFF_FFFF_FFFF_FFFD; lit[1] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
      ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb_v[2] = 64'h1;                   lit[2] = {1'b0, 64'h8000_0000_0000_0000};
      ta[3] = 64'h8000_0000_0000_0000; tb_v[3] = 64'h8000_0000_0000_0000; lit[3] = {1'b1, 64'h0};
      ta[4] = 64'h0;                   tb_v[4] = 64'h0;                   lit[4] = {1'b0, 64'h0};
      ta[5] = 64'h5555_5555_5555_5555; tb_v[5] = 64'hAAAA_AAAA_AAAA_AAAA; lit[5] = {1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
      for (int i = 0; i < 6; i++) begin
         drive(ta[i], tb_v[i], 1'b0);
         e = exp_q.pop_front();
         n_cmp++;
         if ({carry, c} !== e || e !== lit[i]) begin
            n_err++;
            $display("FAIL boundary[%0d]: got carry=%b c=%h, want carry=%b c=%h", i, carry, c, lit[i][64], lit[i][63:0]);
         end
      end
   endtask

   task automatic test_hold();
      logic [64:0] e;
      drive(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
      e = exp_q.pop_front();
      // Operands move mid-cycle; the registered output must not follow them.
      a = 64'hFFFF_FFFF_FFFF_FFFF;
      b = 64'hFFFF_FFFF_FFFF_FFFF;
      #3;
      n_cmp++;
      if ({carry, c} !== e) begin
         n_err++;
         $display("FAIL hold: got carry=%b c=%h, want carry=%b c=%h", carry, c, e[64], e[63:0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] da;
      logic [63:0] db;
      logic [64:0] e;
      for (int i = 0; i < 10; i++) begin
         da = {$urandom, $urandom};
         db = {$urandom, $urandom};
         if (i == 3) db = ~da + 64'd1;
         drive(da, db, (i == 5));
         e = exp_q.pop_front();
         n_cmp++;
         if ({carry, c} !== e) begin
            n_err++;
            $display("FAIL stream[%0d]: got carry=%b c=%h, want carry=%b c=%h", i, carry, c, e[64], e[63:0]);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      a     = '0;
      b     = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_boundaries();
      test_hold();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
